// File: rtl/i2c_write_sequencer_pkg.sv
// Shared types and constants for the I2C write sequencer: FSM encoding, table record layout
// and the master handshake levels.
package i2c_write_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StReq,
    StWait,
    StCheck,
    StGap,
    StFinish
  } seq_state_e;

  // Bit of i2c_status that flags a NACK from the slave.
  localparam int unsigned NackBit = 0;

  // i2c_idle levels driven by the byte-level master.
  localparam logic I2cBusy = 1'b0;
  localparam logic I2cIdle = 1'b1;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] regb;
    logic [7:0] data;
  } seq_entry_t;

endpackage

// File: rtl/i2c_write_sequencer_if.sv
// Bundles the host configuration/control signals and the I2C master handshake.
// The slave modport is the sequencer's view; master is the host/I2C side.
interface i2c_write_sequencer_if #(
  parameter int unsigned IDX_W = 3
);
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_index;
  logic [7:0]       cfg_addr;
  logic [7:0]       cfg_reg;
  logic [7:0]       cfg_data;
  logic [IDX_W:0]   cfg_count;
  logic             cfg_repeat;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             error;
  logic [IDX_W-1:0] cur_index;
  logic [7:0]       last_status;
  logic [7:0]       slave_address;
  logic [7:0]       slave_register;
  logic [7:0]       slave_data;
  logic             enable_send;
  logic             i2c_idle;
  logic [7:0]       i2c_status;

  modport slave (
    input  cfg_we, cfg_index, cfg_addr, cfg_reg, cfg_data, cfg_count, cfg_repeat,
    input  start, abort, i2c_idle, i2c_status,
    output busy, done, error, cur_index, last_status,
    output slave_address, slave_register, slave_data, enable_send
  );

  modport master (
    output cfg_we, cfg_index, cfg_addr, cfg_reg, cfg_data, cfg_count, cfg_repeat,
    output start, abort, i2c_idle, i2c_status,
    input  busy, done, error, cur_index, last_status,
    input  slave_address, slave_register, slave_data, enable_send
  );

endinterface

// File: rtl/i2c_seq_table.sv
// Write-record register file: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module i2c_seq_table
  import i2c_write_sequencer_pkg::*;
#(
  parameter int unsigned NumEntries = 8,
  parameter int unsigned IdxW       = 3
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [IdxW-1:0] waddr_i,
  input  seq_entry_t      wdata_i,
  input  logic [IdxW-1:0] raddr_i,
  output seq_entry_t      rdata_o
);

  seq_entry_t mem_q [NumEntries];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/i2c_write_sequencer.sv
// Replays a table of (address, register, data) write records through the byte-level I2C
// master via the enable_send / i2c_idle handshake, with gap, repeat, abort and timeout.
module i2c_write_sequencer
  import i2c_write_sequencer_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES    = 8,
  parameter int unsigned IDX_W          = 3,
  parameter int unsigned GAP_CYCLES     = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter bit          STOP_ON_NACK   = 1'b1
) (
  input logic                  clock,
  input logic                  reset,
  i2c_write_sequencer_if.slave bus
);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             rpt_q, rpt_d;
  logic             abort_q, abort_d;
  logic             error_q, error_d;
  logic [7:0]       status_q, status_d;
  seq_entry_t       entry_q, entry_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             zdone_q, zdone_d;

  seq_entry_t wr_entry, rd_entry;
  logic       abort_any, is_last, nack;

  assign wr_entry = {bus.cfg_addr, bus.cfg_reg, bus.cfg_data};

  i2c_seq_table #(
    .NumEntries(NUM_ENTRIES),
    .IdxW      (IDX_W)
  ) u_table (
    .clk_i  (clock),
    .we_i   (bus.cfg_we && (state_q == StIdle)),
    .waddr_i(bus.cfg_index),
    .wdata_i(wr_entry),
    .raddr_i(idx_q),
    .rdata_o(rd_entry)
  );

  assign abort_any = abort_q | bus.abort;
  assign is_last   = ({1'b0, idx_q} == (count_q - (IDX_W + 1)'(1)));
  assign nack      = bus.i2c_status[NackBit];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    count_d  = count_q;
    rpt_d    = rpt_q;
    abort_d  = abort_q;
    error_d  = error_q;
    status_d = status_q;
    entry_d  = entry_q;
    cnt_d    = cnt_q;
    zdone_d  = 1'b0;

    if ((state_q != StIdle) && bus.abort) begin
      abort_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        // Start has priority over a coincident abort, which is meaningless here.
        abort_d = 1'b0;
        if (bus.start) begin
          error_d = 1'b0;
          if (bus.cfg_count == '0) begin
            zdone_d = 1'b1;
          end else begin
            status_d = '0;
            idx_d    = '0;
            count_d  = bus.cfg_count;
            rpt_d    = bus.cfg_repeat;
            state_d  = StLoad;
          end
        end
      end
      StLoad: begin
        if (abort_any) begin
          state_d = StFinish;
        end else begin
          entry_d = rd_entry;
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.i2c_idle == I2cBusy) begin
          cnt_d   = '0;
          state_d = StWait;
        end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
          error_d = 1'b1;
          state_d = StFinish;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StWait: begin
        if (bus.i2c_idle == I2cIdle) begin
          state_d = StCheck;
        end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
          error_d = 1'b1;
          state_d = StFinish;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StCheck: begin
        status_d = bus.i2c_status;
        if (nack) begin
          error_d = 1'b1;
        end
        if (nack && STOP_ON_NACK) begin
          state_d = StFinish;
        end else if ((is_last && !rpt_q) || abort_any) begin
          state_d = StFinish;
        end else begin
          idx_d   = is_last ? '0 : idx_q + IDX_W'(1);
          cnt_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (abort_any) begin
          state_d = StFinish;
        end else if (cnt_q == GAP_CYCLES - 1) begin
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StFinish: begin
        abort_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      count_q  <= '0;
      rpt_q    <= 1'b0;
      abort_q  <= 1'b0;
      error_q  <= 1'b0;
      status_q <= '0;
      entry_q  <= '0;
      cnt_q    <= '0;
      zdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      rpt_q    <= rpt_d;
      abort_q  <= abort_d;
      error_q  <= error_d;
      status_q <= status_d;
      entry_q  <= entry_d;
      cnt_q    <= cnt_d;
      zdone_q  <= zdone_d;
    end
  end

  assign bus.busy           = (state_q != StIdle);
  assign bus.done           = (state_q == StFinish) | zdone_q;
  assign bus.error          = error_q;
  assign bus.cur_index      = idx_q;
  assign bus.last_status    = status_q;
  assign bus.slave_address  = entry_q.addr;
  assign bus.slave_register = entry_q.regb;
  assign bus.slave_data     = entry_q.data;
  assign bus.enable_send    = (state_q == StReq);

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Directed bench for i2c_write_sequencer with a simple byte-level I2C master model.
module tb_i2c_write_sequencer;

  localparam int unsigned Gap = 8;
  localparam int unsigned Tmo = 200;

  logic clock;
  logic reset;

  i2c_write_sequencer_if #(.IDX_W(3)) bus ();

  i2c_write_sequencer #(
    .NUM_ENTRIES   (8),
    .IDX_W         (3),
    .GAP_CYCLES    (Gap),
    .TIMEOUT_CYCLES(Tmo),
    .STOP_ON_NACK  (1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  bit          en_seen = 0;
  int          req_cnt = 0;
  logic [23:0] req_log [16];
  int          req_cyc [16];
  int          end_cyc [16];
  int          nack_idx = -1;
  bit          hang = 0;
  int          m_ent;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_entry(input int idx, input logic [7:0] a, input logic [7:0] r,
                             input logic [7:0] d);
    bus.cfg_index = 3'(idx);
    bus.cfg_addr  = a;
    bus.cfg_reg   = r;
    bus.cfg_data  = d;
    bus.cfg_we    = 1'b1;
    @(posedge clock);
    #1 bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input int count, input bit rpt);
    bus.cfg_count  = 4'(count);
    bus.cfg_repeat = rpt;
    bus.start      = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_eq(tag, 32'(bus.done), 32'd1);
  endtask

  // Monitor: cycle count, done pulses and any enable_send activity.
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      if (bus.done) done_cnt++;
      if (bus.enable_send) en_seen = 1'b1;
    end
  end

  // I2C master model: accepts a request, runs busy for a few cycles, reports status.
  initial begin
    bus.i2c_idle   = 1'b1;
    bus.i2c_status = 8'h00;
    forever begin
      @(posedge clock);
      #1;
      if (bus.enable_send && !hang) begin
        if (req_cnt < 16) begin
          req_log[req_cnt] = {bus.slave_address, bus.slave_register, bus.slave_data};
          req_cyc[req_cnt] = cyc;
        end
        m_ent = int'(bus.cur_index);
        req_cnt++;
        repeat (2) @(posedge clock);
        #1 bus.i2c_idle = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        bus.i2c_status = (m_ent == nack_idx) ? 8'h01 : 8'h00;
        bus.i2c_idle   = 1'b1;
        if (req_cnt <= 16) end_cyc[req_cnt-1] = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t0;
    reset          = 1'b1;
    bus.cfg_we     = 1'b0;
    bus.cfg_index  = '0;
    bus.cfg_addr   = '0;
    bus.cfg_reg    = '0;
    bus.cfg_data   = '0;
    bus.cfg_count  = '0;
    bus.cfg_repeat = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_done", 32'(bus.done), 0);
    check_eq("rst_error", 32'(bus.error), 0);
    check_eq("rst_en", 32'(bus.enable_send), 0);
    check_eq("rst_slave", {8'h0, bus.slave_address, bus.slave_register, bus.slave_data}, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Test 1: three entries, one-shot.
    write_entry(0, 8'hC0, 8'h16, 8'hF0);
    write_entry(1, 8'hC0, 8'h16, 8'hF5);
    write_entry(2, 8'hC0, 8'h17, 8'hAA);
    req_cnt  = 0;
    done_cnt = 0;
    pulse_start(3, 1'b0);
    check_eq("t1_busy", 32'(bus.busy), 1);
    wait_done("t1_done", 400);
    check_eq("t1_busy_at_done", 32'(bus.busy), 1);
    @(posedge clock);
    #1;
    check_eq("t1_busy_after", 32'(bus.busy), 0);
    check_eq("t1_error", 32'(bus.error), 0);
    check_eq("t1_status", 32'(bus.last_status), 0);
    repeat (20) @(posedge clock);
    #1;
    check_eq("t1_req_cnt", req_cnt, 3);
    check_eq("t1_req0", 32'(req_log[0]), 32'hC016F0);
    check_eq("t1_req1", 32'(req_log[1]), 32'hC016F5);
    check_eq("t1_req2", 32'(req_log[2]), 32'hC017AA);
    check_eq("t1_gap01", 32'((req_cyc[1] - end_cyc[0]) >= int'(Gap)), 1);
    check_eq("t1_gap12", 32'((req_cyc[2] - end_cyc[1]) >= int'(Gap)), 1);
    check_eq("t1_done_cnt", done_cnt, 1);

    // Test 2: repeat, abort during second transaction of the second pass.
    req_cnt  = 0;
    done_cnt = 0;
    pulse_start(3, 1'b1);
    n = 0;
    while (req_cnt < 5 && n < 600) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_eq("t2_reach5", 32'(req_cnt >= 5), 1);
    bus.abort = 1'b1;
    @(posedge clock);
    #1 bus.abort = 1'b0;
    wait_done("t2_done", 200);
    @(posedge clock);
    #1;
    check_eq("t2_busy_after", 32'(bus.busy), 0);
    check_eq("t2_cur_index", 32'(bus.cur_index), 1);
    repeat (30) @(posedge clock);
    #1;
    check_eq("t2_req_cnt", req_cnt, 5);
    check_eq("t2_req3", 32'(req_log[3]), 32'hC016F0);
    check_eq("t2_req4", 32'(req_log[4]), 32'hC016F5);
    check_eq("t2_done_cnt", done_cnt, 1);
    check_eq("t2_error", 32'(bus.error), 0);

    // Test 3: NACK on entry 1 aborts the run.
    req_cnt  = 0;
    done_cnt = 0;
    nack_idx = 1;
    pulse_start(3, 1'b0);
    wait_done("t3_done", 400);
    check_eq("t3_error", 32'(bus.error), 1);
    check_eq("t3_status", 32'(bus.last_status), 32'h01);
    repeat (30) @(posedge clock);
    #1;
    check_eq("t3_req_cnt", req_cnt, 2);
    check_eq("t3_done_cnt", done_cnt, 1);
    check_eq("t3_error_sticky", 32'(bus.error), 1);
    nack_idx = -1;

    // Test 4: master never responds.
    req_cnt  = 0;
    done_cnt = 0;
    hang     = 1'b1;
    pulse_start(3, 1'b0);
    t0 = cyc;
    wait_done("t4_done", 400);
    check_eq("t4_elapsed", 32'(((cyc - t0) >= int'(Tmo)) && ((cyc - t0) <= int'(Tmo) + 3)), 1);
    check_eq("t4_error", 32'(bus.error), 1);
    check_eq("t4_en", 32'(bus.enable_send), 0);
    @(posedge clock);
    #1;
    hang = 1'b0;
    check_eq("t4_busy_after", 32'(bus.busy), 0);
    check_eq("t4_req_cnt", req_cnt, 0);

    // Test 5: zero-length run.
    en_seen  = 1'b0;
    done_cnt = 0;
    pulse_start(0, 1'b0);
    check_eq("t5_done_next", 32'(bus.done), 1);
    check_eq("t5_busy", 32'(bus.busy), 0);
    @(posedge clock);
    #1;
    check_eq("t5_done_pulse", 32'(bus.done), 0);
    repeat (10) @(posedge clock);
    #1;
    check_eq("t5_en_seen", 32'(en_seen), 0);
    check_eq("t5_done_cnt", done_cnt, 1);

    // Test 5b: table write while busy is dropped.
    req_cnt = 0;
    pulse_start(1, 1'b0);
    write_entry(0, 8'h11, 8'h22, 8'h33);
    wait_done("t5b_done1", 200);
    check_eq("t5b_error_cleared", 32'(bus.error), 0);
    @(posedge clock);
    #1;
    pulse_start(1, 1'b0);
    wait_done("t5b_done2", 200);
    repeat (5) @(posedge clock);
    #1;
    check_eq("t5b_req_cnt", req_cnt, 2);
    check_eq("t5b_req1", 32'(req_log[1]), 32'hC016F0);

    // Test 6: asynchronous reset during WAIT, then a clean rerun.
    pulse_start(3, 1'b0);
    n = 0;
    while (bus.i2c_idle && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_eq("t6_bus_busy", 32'(bus.i2c_idle), 0);
    @(posedge clock);
    #1;
    check_eq("t6_wait_en", 32'(bus.enable_send), 0);
    reset = 1'b1;
    #1;
    check_eq("t6_rst_ctl", {27'h0, bus.busy, bus.done, bus.error, bus.enable_send, 1'b0}, 0);
    check_eq("t6_rst_slave", {8'h0, bus.slave_address, bus.slave_register, bus.slave_data}, 0);
    check_eq("t6_rst_idx", {21'h0, bus.cur_index, bus.last_status}, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    n = 0;
    while (!bus.i2c_idle && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    repeat (3) @(posedge clock);
    #1;
    req_cnt = 0;
    pulse_start(3, 1'b0);
    wait_done("t6_done", 400);
    repeat (5) @(posedge clock);
    #1;
    check_eq("t6_req_cnt", req_cnt, 3);
    check_eq("t6_req0", 32'(req_log[0]), 32'hC016F0);
    check_eq("t6_req2", 32'(req_log[2]), 32'hC017AA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_write_sequencer.md
Name: i2c_write_sequencer

Overview:
Parametrised successor to the single-transaction I2C write test driver. Holds a programmable table of up to NUM_ENTRIES (slave address, register, data) write records and replays them in order through the existing byte-level I2C master write engine, using a request/idle handshake. Supports one-shot or continuous repeat, inter-transaction gap, NACK abort and handshake timeout. Sits between board-level control (switches/LEDs or a host register block) and the I2C master.

Parameters:
NUM_ENTRIES, 8, table depth (2..256)
IDX_W, 3, index width, equals clog2(NUM_ENTRIES)
GAP_CYCLES, 1000, clock cycles idle between transactions (>=1)
TIMEOUT_CYCLES, 5000000, max cycles in any handshake wait before error (>=2)
STOP_ON_NACK, 1, 1 = abort sequence on NACK; 0 = flag it and continue

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-high reset
cfg_we  in  1  table write strobe (ignored while busy)
cfg_index  in  IDX_W  table entry written
cfg_addr  in  8  slave address byte (R/W bit included, e.g. 8'hC0)
cfg_reg  in  8  register byte
cfg_data  in  8  data byte
cfg_count  in  IDX_W+1  number of entries to play (0 = none); sampled at start
cfg_repeat  in  1  1 = restart at entry 0 after last; sampled at start
start  in  1  single-cycle pulse, starts sequence from entry 0
abort  in  1  single-cycle pulse, stop after current transaction
busy  out  1  sequence active
done  out  1  one-cycle pulse when sequence ends normally or by abort
error  out  1  sticky; set on NACK or timeout; cleared by start
cur_index  out  IDX_W  entry being played
last_status  out  8  i2c_status captured at end of last transaction
slave_address  out  8  to master
slave_register  out  8  to master
slave_data  out  8  to master
enable_send  out  1  request to master
i2c_idle  in  1  from master: 1 = idle, 0 = transaction running
i2c_status  in  8  from master; bit0 = NACK seen

Behaviour:
- Reset: all outputs 0, state IDLE, table contents undefined (not reset), timeout/gap counters 0, latched abort 0.
- Table: synchronous write on cfg_we when not busy; write during busy dropped.
- IDLE: start with cfg_count==0 -> done pulse next cycle, stay IDLE. start with cfg_count>0 -> clear error and last_status, index=0, latch count/repeat, go LOAD.
- LOAD (1 cycle): drive slave_* from table[index]; these stay stable until next LOAD.
- REQ: enable_send=1; leave when i2c_idle==0 -> WAIT. enable_send drops on the same edge as the REQ->WAIT transition.
- WAIT: enable_send=0; on i2c_idle==1 -> CHECK.
- CHECK (1 cycle): last_status<=i2c_status. If bit0 set: error<=1; STOP_ON_NACK=1 -> FINISH. Otherwise: last entry (index==count-1) and !repeat, or abort latched -> FINISH; else index<=next (wraps to 0 after count-1 when repeat), go GAP.
- GAP: count GAP_CYCLES, then LOAD.
- FINISH: done=1 one cycle, busy=0 next cycle, back to IDLE.
- Timeout: counter cleared on entering REQ/WAIT; reaching TIMEOUT_CYCLES sets error, enable_send=0, go FINISH.
- abort: latched in any non-IDLE state. In GAP/LOAD -> FINISH immediately. In REQ/WAIT it takes effect at CHECK, never cuts a bus transaction. Abort in IDLE is ignored. start while busy is ignored.
- Simultaneous start and abort in IDLE: start wins, abort ignored.
- busy=1 in every state except IDLE.
- cur_index is valid whenever busy.
- Reset mid-transaction: immediate return to IDLE with enable_send=0.

Decomposition:
- Shared package: state encoding constants (IDLE, LOAD, REQ, WAIT, CHECK, GAP, FINISH), NACK status bit position, not-busy/busy level constants for the master handshake.
- Natural sub-module: i2c_seq_table, an NUM_ENTRIES x 24-bit register file with one sync write port and one async read port.

Test Plan:
- Load 3 entries (C0/16/F0, C0/16/F5, C0/17/AA), count=3, repeat=0, master model ACKs -> three requests in order, gap >= GAP_CYCLES between them, single done, error=0, last_status=00.
- Same table, repeat=1, abort pulsed during 2nd transaction of 2nd pass -> that transaction completes, then done, busy=0, cur_index=1.
- Master returns status 01 on entry 1, STOP_ON_NACK=1 -> error=1, last_status=01, done after entry 1, entry 2 never requested.
- Master never drops i2c_idle -> after TIMEOUT_CYCLES error=1, enable_send=0, done pulse.
- cfg_count=0 with start -> done next cycle, enable_send never asserted. cfg_we while busy -> table unchanged on next run.
- Assert reset during WAIT -> all outputs 0 asynchronously. A new start then runs the full sequence from entry 0.
